tick_rate_controller: RTL and testbench
=======================================

Name: tick_rate_controller

Overview:
Runtime-configurable clock-enable generator. It sequences a half-period divider core to produce a 50% square wave and a one-cycle tick pulse per period.
Divide ratio and burst length are loaded through a valid/ready config handshake. New settings are applied glitch-free, only at period boundaries.
It replaces fixed compile-time dividers wherever lab peripherals (display scan, debouncers, blinkers) need a rate that changes at run time.

Parameters:
F_IN, 100_000_000, input clock frequency in Hz
F_OUT_DEFAULT, 10, output frequency after reset in Hz; reset half-period = F_IN/(2*F_OUT_DEFAULT), truncated
DIV_WIDTH, 24, width of half-period register and counter; must hold reset half-period

Ports:
clk_in  input  1  single system clock, all logic on posedge
reset  input  1  synchronous, active-low; 0 at a posedge resets the block
start  input  1  level-sampled request to begin generating
stop  input  1  request graceful stop at end of current period
cfg_valid  input  1  config offer
cfg_ready  output  1  config accepted when cfg_valid && cfg_ready at a posedge
cfg_half_period  input  DIV_WIDTH  half-period in clk_in cycles; 0 is clamped to 1
cfg_burst_len  input  8  ticks per run; 0 = continuous
sq_out  output  1  square wave, period 2*H cycles
tick_out  output  1  one-cycle pulse, coincident with each sq_out rise
busy  output  1  high in RUN
done  output  1  one-cycle pulse when a run ends (burst complete or stop)

Behaviour:
- Reset (reset==0 at posedge), all registered:
  - state=IDLE; counter=0; sq_out=0; tick_out=0; busy=0; done=0; cfg_ready=1; no pending config.
  - Active H = reset half-period; active burst = 0.
- States: IDLE, RUN, DRAIN (finishing current period before IDLE).
- IDLE:
  - start=1 and stop=0 → RUN next edge, counter=0.
  - start and stop together → stay IDLE.
  - An accepted config is written to the active registers at the accepting edge and used by the next run.
- RUN counter behaviour:
  - Counter increments by 1 each cycle.
  - At counter==H-1: counter←0 and sq_out toggles.
  - On a 0→1 toggle, tick_out=1 for that cycle (registered together with sq_out).
  - First tick comes exactly H cycles after the edge that sampled start; ticks repeat every 2H cycles.
- Config while RUN/DRAIN:
  - An accepted config goes to a pending register; cfg_ready drops to 0.
  - Applied at the next falling boundary (counter==H-1 with sq_out==1): counter restarts at 0 under the new H, and the burst count is reloaded.
  - cfg_ready returns to 1 on the following cycle.
  - Never applied mid-period. H changes do not shorten or stretch the current period.
- Burst:
  - Tick counter increments on each tick.
  - When ticks == burst_len (burst_len≠0), state goes to DRAIN, which completes the current high phase.
  - At the falling boundary: sq_out=0, state=IDLE, busy=0, done=1 for one cycle.
- stop in RUN: go to DRAIN and finish the current period. If sq_out==0 when stop is sampled, finish the low phase and the high phase, giving one last tick. stop in DRAIN is ignored.
- start while RUN/DRAIN is ignored.
- Simultaneous burst end and pending config at one boundary: go to IDLE and install the pending config.
- H=1: sq_out toggles every cycle and tick_out pulses every 2 cycles.
- Counter and tick count wrap only via the explicit compares, never by overflow.
- busy=1 exactly in RUN/DRAIN.
- Reset mid-run: outputs return to reset values at that edge, no done pulse, pending config discarded.

Decomposition:
- Package tick_rate_pkg:
  - state enum (IDLE, RUN, DRAIN)
  - BURST_WIDTH=8
  - function computing default half-period from F_IN/F_OUT_DEFAULT
- One sub-module, half_period_counter, holding counter and sq_out toggle logic with load/clear/enable inputs.
- The FSM, config/pending registers and burst counter stay in the top module.

Test Plan:
- Reset, then release with F_IN=100, F_OUT_DEFAULT=10, start pulse → first tick_out 5 cycles after the start edge, then every 10; sq_out high 5 and low 5.
- Config H=2, burst=3 in IDLE, then start → ticks at +2, +6, +10; done=1 and busy=0 at +12; sq_out=0 after.
- Continuous H=4; at cycle 6 offer H=1 → cfg_ready=0 until the boundary at cycle 8. Next rising edge at +1 after the boundary, period 2 after; cfg_ready=1 at cycle 9.
- cfg_half_period=0 → behaves as H=1 (tick every 2 cycles).
- Continuous H=3; stop while sq_out low at cycle 1 → one more tick at cycle 3, done at cycle 6, busy=0.
- Reset asserted mid-burst with a pending config → next cycle all outputs at reset values, no done; a following start uses the pre-run active H, not the discarded pending H.

Source files
------------

// File: rtl/tick_rate_pkg.sv
`default_nettype none
// ============================================================================
// Package     : tick_rate_pkg
// Description : Shared types and helpers for the tick rate controller.
// Revision    : 1.0 - initial release
// ============================================================================
package tick_rate_pkg;

    localparam int BURST_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Half-period after reset; never below one cycle so the counter compare stays sane.
    function automatic int default_half_period(input int f_in, input int f_out);
        int h;
        if (f_out > 0) begin
            h = f_in / (2 * f_out);
        end else begin
            h = 1;
        end
        if (h < 1) begin
            h = 1;
        end
        return h;
    endfunction

endpackage
`default_nettype wire

// File: rtl/half_period_counter.sv
`default_nettype none
// ============================================================================
// Module      : half_period_counter
// Description : Half-period counter with square-wave toggle and rise tick.
// Revision    : 1.0 - initial release
// ============================================================================
module half_period_counter
    import tick_rate_pkg::*;
#(
    parameter int DIV_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_clear,
    input  logic                 i_load,
    input  logic                 i_enable,
    input  logic [DIV_WIDTH-1:0] i_half_period,
    output logic                 o_sq,
    output logic                 o_tick,
    output logic                 o_rise,
    output logic                 o_fall
);

    logic [DIV_WIDTH-1:0] count_q, count_d;
    logic                 sq_q, sq_d;
    logic                 tick_q, tick_d;
    logic                 wrap;

    assign wrap   = i_enable && (count_q == (i_half_period - 1'b1));
    assign o_rise = wrap && !sq_q;
    assign o_fall = wrap && sq_q;
    assign o_sq   = sq_q;
    assign o_tick = tick_q;

    always_comb begin
        count_d = count_q;
        sq_d    = sq_q;
        tick_d  = 1'b0;
        if (i_clear) begin
            count_d = '0;
            sq_d    = 1'b0;
        end else if (i_load) begin
            count_d = '0;
        end else if (i_enable) begin
            if (wrap) begin
                count_d = '0;
                sq_d    = ~sq_q;
                tick_d  = ~sq_q;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            sq_q    <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            sq_q    <= sq_d;
            tick_q  <= tick_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tick_rate_controller.sv
`default_nettype none
// ============================================================================
// Module      : tick_rate_controller
// Description : Runtime-configurable square-wave / tick generator with bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_rate_controller
    import tick_rate_pkg::*;
#(
    parameter int F_IN          = 100_000_000,
    parameter int F_OUT_DEFAULT = 10,
    parameter int DIV_WIDTH     = 24
) (
    input  logic                   clk_in,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [DIV_WIDTH-1:0]   cfg_half_period,
    input  logic [BURST_WIDTH-1:0] cfg_burst_len,
    output logic                   sq_out,
    output logic                   tick_out,
    output logic                   busy,
    output logic                   done
);

    localparam logic [DIV_WIDTH-1:0] H_RESET =
        DIV_WIDTH'(default_half_period(F_IN, F_OUT_DEFAULT));

    state_e                 state_q, state_d;
    logic [DIV_WIDTH-1:0]   half_q, half_d;
    logic [BURST_WIDTH-1:0] burst_q, burst_d;
    logic [BURST_WIDTH-1:0] ticks_q, ticks_d;
    logic                   pend_valid_q, pend_valid_d;
    logic [DIV_WIDTH-1:0]   pend_half_q, pend_half_d;
    logic [BURST_WIDTH-1:0] pend_burst_q, pend_burst_d;
    logic                   cfg_ready_q, cfg_ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   accept;
    logic [DIV_WIDTH-1:0]   half_clamped;
    logic [BURST_WIDTH-1:0] ticks_inc;
    logic                   ctr_clear, ctr_load, ctr_enable;
    logic                   ctr_rise, ctr_fall;

    half_period_counter #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_counter (
        .clk           (clk_in),
        .rst_n         (reset),
        .i_clear       (ctr_clear),
        .i_load        (ctr_load),
        .i_enable      (ctr_enable),
        .i_half_period (half_q),
        .o_sq          (sq_out),
        .o_tick        (tick_out),
        .o_rise        (ctr_rise),
        .o_fall        (ctr_fall)
    );

    always_comb begin
        accept       = cfg_valid && cfg_ready_q;
        half_clamped = (cfg_half_period == '0) ? DIV_WIDTH'(1) : cfg_half_period;
        ticks_inc    = ticks_q + 1'b1;

        state_d      = state_q;
        half_d       = half_q;
        burst_d      = burst_q;
        ticks_d      = ticks_q;
        pend_valid_d = pend_valid_q;
        pend_half_d  = pend_half_q;
        pend_burst_d = pend_burst_q;
        done_d       = 1'b0;
        ctr_clear    = 1'b0;
        ctr_load     = 1'b0;
        ctr_enable   = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    half_d  = half_clamped;
                    burst_d = cfg_burst_len;
                end
                if (start && !stop) begin
                    state_d  = RUN;
                    ctr_load = 1'b1;
                    ticks_d  = '0;
                end
            end
            RUN: begin
                if (ctr_rise && (burst_q != '0)) begin
                    ticks_d = ticks_inc;
                    if (ticks_inc == burst_q) begin
                        state_d = DRAIN;
                    end
                end
                if (stop) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = DRAIN;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Falling boundary is the only point where settings may change or a run may end.
        if (ctr_fall) begin
            if (pend_valid_q) begin
                half_d       = pend_half_q;
                burst_d      = pend_burst_q;
                ticks_d      = '0;
                pend_valid_d = 1'b0;
            end
            if (state_q == DRAIN) begin
                state_d   = IDLE;
                done_d    = 1'b1;
                ctr_clear = 1'b1;
                ticks_d   = '0;
            end
        end

        if (accept && (state_q != IDLE)) begin
            pend_valid_d = 1'b1;
            pend_half_d  = half_clamped;
            pend_burst_d = cfg_burst_len;
        end

        cfg_ready_d = !pend_valid_q && !(accept && (state_q != IDLE));
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state_q      <= IDLE;
            half_q       <= H_RESET;
            burst_q      <= '0;
            ticks_q      <= '0;
            pend_valid_q <= 1'b0;
            pend_half_q  <= '0;
            pend_burst_q <= '0;
            cfg_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            half_q       <= half_d;
            burst_q      <= burst_d;
            ticks_q      <= ticks_d;
            pend_valid_q <= pend_valid_d;
            pend_half_q  <= pend_half_d;
            pend_burst_q <= pend_burst_d;
            cfg_ready_q  <= cfg_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_tick_rate_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_tick_rate_controller
// Description : Scoreboard bench for tick_rate_controller (F_IN=100, F_OUT=10).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tick_rate_controller;

    localparam int DW = 8;

    logic          clk_in = 1'b0;
    logic          reset;
    logic          start;
    logic          stop;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [DW-1:0] cfg_half_period;
    logic [7:0]    cfg_burst_len;
    logic          sq_out;
    logic          tick_out;
    logic          busy;
    logic          done;

    tick_rate_controller #(
        .F_IN          (100),
        .F_OUT_DEFAULT (10),
        .DIV_WIDTH     (DW)
    ) dut (
        .clk_in          (clk_in),
        .reset           (reset),
        .start           (start),
        .stop            (stop),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_half_period (cfg_half_period),
        .cfg_burst_len   (cfg_burst_len),
        .sq_out          (sq_out),
        .tick_out        (tick_out),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk_in = ~clk_in;

    // cyc equals the index of the most recent posedge
    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        int at;
        int kind;   // 1 = tick, 2 = done
    } ev_t;

    ev_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic push(input int at, input int kind);
        ev_t e;
        e.at   = at;
        e.kind = kind;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk_in);
    endtask

    task automatic configure(input int h, input int b);
        @(negedge clk_in);
        cfg_valid       = 1'b1;
        cfg_half_period = DW'(h);
        cfg_burst_len   = 8'(b);
        @(negedge clk_in);
        cfg_valid       = 1'b0;
    endtask

    task automatic start_run(output int s);
        @(negedge clk_in);
        start = 1'b1;
        s     = cyc + 1;
        @(negedge clk_in);
        start = 1'b0;
    endtask

    // Monitor: every tick/done the DUT shows is matched against the scoreboard.
    int  mon_kind;
    ev_t mon_e;
    always @(negedge clk_in) begin
        if (tick_out === 1'b1 || done === 1'b1) begin
            mon_kind = (done === 1'b1) ? 2 : 1;
            if (exp_q.size() == 0) begin
                chk("unexpected_event", 32'(mon_kind), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("event_cycle", 32'(cyc), 32'(mon_e.at));
                chk("event_kind", 32'(mon_kind), 32'(mon_e.kind));
                chk("event_sq", 32'(sq_out), 32'(mon_e.kind == 1));
                chk("event_busy", 32'(busy), 32'(mon_e.kind == 1));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "time limit");
    end

    int s;

    initial begin
        reset           = 1'b0;
        start           = 1'b0;
        stop            = 1'b0;
        cfg_valid       = 1'b0;
        cfg_half_period = '0;
        cfg_burst_len   = '0;
        repeat (3) @(negedge clk_in);
        chk("rst_sq", 32'(sq_out), 32'd0);
        chk("rst_tick", 32'(tick_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        reset = 1'b1;

        // Default H=5 continuous, stop sampled while high
        start_run(s);
        push(s + 5, 1); push(s + 15, 1); push(s + 25, 1); push(s + 30, 2);
        wait_cyc(s + 5);  chk("t1_sq_hi_first", 32'(sq_out), 32'd1);
        wait_cyc(s + 9);  chk("t1_sq_hi_last", 32'(sq_out), 32'd1);
        wait_cyc(s + 10); chk("t1_sq_lo_first", 32'(sq_out), 32'd0);
        wait_cyc(s + 14); chk("t1_sq_lo_last", 32'(sq_out), 32'd0);
        wait_cyc(s + 26); stop = 1'b1;
        @(negedge clk_in); stop = 1'b0;
        wait_cyc(s + 32);
        chk("t1_drained", 32'(exp_q.size()), 32'd0);
        chk("t1_busy_end", 32'(busy), 32'd0);

        // start together with stop keeps the block idle
        @(negedge clk_in); start = 1'b1; stop = 1'b1;
        @(negedge clk_in); start = 1'b0; stop = 1'b0;
        chk("startstop_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk_in);
        chk("startstop_busy_later", 32'(busy), 32'd0);

        // H=2, burst of 3
        configure(2, 3);
        chk("t2_cfg_ready_idle", 32'(cfg_ready), 32'd1);
        start_run(s);
        push(s + 2, 1); push(s + 6, 1); push(s + 10, 1); push(s + 12, 2);
        wait_cyc(s + 11); chk("t2_busy_drain", 32'(busy), 32'd1);
        wait_cyc(s + 13);
        chk("t2_sq_after", 32'(sq_out), 32'd0);
        chk("t2_busy_after", 32'(busy), 32'd0);
        chk("t2_drained", 32'(exp_q.size()), 32'd0);

        // H=4 continuous, switch to H=1 mid-run
        configure(4, 0);
        start_run(s);
        push(s + 4, 1); push(s + 9, 1); push(s + 11, 1); push(s + 13, 1);
        push(s + 15, 1); push(s + 16, 2);
        wait_cyc(s + 5);
        cfg_valid = 1'b1; cfg_half_period = DW'(1); cfg_burst_len = 8'd0;
        @(negedge clk_in); cfg_valid = 1'b0;
        chk("t3_ready_c6", 32'(cfg_ready), 32'd0);
        wait_cyc(s + 7); chk("t3_ready_c7", 32'(cfg_ready), 32'd0);
        wait_cyc(s + 8);
        chk("t3_ready_c8", 32'(cfg_ready), 32'd0);
        chk("t3_sq_c8", 32'(sq_out), 32'd0);
        wait_cyc(s + 9); chk("t3_ready_c9", 32'(cfg_ready), 32'd1);
        wait_cyc(s + 14); stop = 1'b1;
        @(negedge clk_in); stop = 1'b0;
        wait_cyc(s + 18);
        chk("t3_drained", 32'(exp_q.size()), 32'd0);

        // Zero half-period is clamped to 1, burst of 2
        configure(0, 2);
        start_run(s);
        push(s + 1, 1); push(s + 3, 1); push(s + 4, 2);
        wait_cyc(s + 6);
        chk("t4_drained", 32'(exp_q.size()), 32'd0);
        chk("t4_busy_end", 32'(busy), 32'd0);

        // H=3, stop sampled while low at cycle 1
        configure(3, 0);
        @(negedge clk_in); start = 1'b1; s = cyc + 1;
        @(negedge clk_in); start = 1'b0; stop = 1'b1;
        @(negedge clk_in); stop = 1'b0;
        push(s + 3, 1); push(s + 6, 2);
        wait_cyc(s + 8);
        chk("t5_drained", 32'(exp_q.size()), 32'd0);
        chk("t5_busy_end", 32'(busy), 32'd0);

        // Reset mid-burst with a pending config
        configure(5, 3);
        start_run(s);
        push(s + 5, 1);
        wait_cyc(s + 6);
        cfg_valid = 1'b1; cfg_half_period = DW'(2); cfg_burst_len = 8'd0;
        @(negedge clk_in); cfg_valid = 1'b0;
        chk("t6_ready_pending", 32'(cfg_ready), 32'd0);
        wait_cyc(s + 8); reset = 1'b0;
        @(negedge clk_in);
        chk("t6_rst_sq", 32'(sq_out), 32'd0);
        chk("t6_rst_tick", 32'(tick_out), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_done", 32'(done), 32'd0);
        chk("t6_rst_ready", 32'(cfg_ready), 32'd1);
        reset = 1'b1;
        repeat (3) @(negedge clk_in);
        chk("t6_no_done", 32'(exp_q.size()), 32'd0);
        start_run(s);
        push(s + 5, 1); push(s + 15, 1); push(s + 20, 2);
        wait_cyc(s + 16); stop = 1'b1;
        @(negedge clk_in); stop = 1'b0;
        wait_cyc(s + 22);
        chk("t6_drained", 32'(exp_q.size()), 32'd0);
        chk("t6_busy_end", 32'(busy), 32'd0);

        repeat (2) @(negedge clk_in);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
